// File: rtl/spec_commit_buffer_if.sv
// Handshake bundle between a speculative producer, the commit buffer and a
// committed-state consumer. The master side is the environment around the
// buffer (producer, resolver and consumer); the slave side is the buffer.
interface spec_commit_buffer_if #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4,
    parameter int CNT_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [TAG_W-1:0] in_tag;
    logic             resolve_valid;
    logic [TAG_W-1:0] resolve_tag;
    logic             kill_valid;
    logic [TAG_W-1:0] kill_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] count;

    modport master (
        output in_valid, in_data, in_tag,
        output resolve_valid, resolve_tag,
        output kill_valid, kill_tag,
        output out_ready,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  in_valid, in_data, in_tag,
        input  resolve_valid, resolve_tag,
        input  kill_valid, kill_tag,
        input  out_ready,
        output in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/spec_commit_buffer.sv
// In-order buffer holding speculatively produced words until their tag
// resolves. Only non-speculative words leave at the head; a kill squashes
// the oldest matching entry and everything younger than it.
module spec_commit_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    spec_commit_buffer_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [TAG_W-1:0] tag_q  [DEPTH];
    logic [TAG_W-1:0] tag_d  [DEPTH];
    logic [DEPTH-1:0] spec_q, spec_d;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    logic             kill_hit;
    logic [CW-1:0]    kill_k;
    logic             in_ready;
    logic             out_valid;
    logic             enq;
    logic             deq;

    // Find the oldest occupied entry carrying the kill tag; scanning from the
    // youngest offset down lets the oldest match overwrite the younger ones.
    always_comb begin
        kill_hit = 1'b0;
        kill_k   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (bus.kill_valid && (CW'(i) < count_q)
                && (tag_q[head_q + PW'(i)] == bus.kill_tag)) begin
                kill_hit = 1'b1;
                kill_k   = CW'(i);
            end
        end
    end

    // Handshake: a kill blocks intake, and a head being killed is never shown.
    always_comb begin
        in_ready  = (count_q < FULL) && !bus.kill_valid;
        out_valid = (count_q != '0) && !spec_q[head_q]
                    && !(bus.kill_valid && (bus.kill_tag == tag_q[head_q]));
        enq       = bus.in_valid && in_ready;
        deq       = out_valid && bus.out_ready;
    end

    // Next state: resolve clears spec bits, then either a kill truncates the
    // queue (optionally popping a surviving head) or normal enqueue/dequeue.
    always_comb begin
        logic [PW-1:0] off;
        data_d  = data_q;
        tag_d   = tag_q;
        spec_d  = spec_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        off     = '0;

        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - head_q;
            if (bus.resolve_valid && (CW'(off) < count_q)
                && (tag_q[i] == bus.resolve_tag)) begin
                spec_d[i] = 1'b0;
            end
        end

        if (kill_hit) begin
            tail_d  = head_q + kill_k[PW-1:0];
            count_d = kill_k;
            if (deq) begin
                head_d  = head_q + 1'b1;
                count_d = kill_k - 1'b1;
            end
        end else begin
            if (enq) begin
                data_d[tail_q] = bus.in_data;
                tag_d[tail_q]  = bus.in_tag;
                spec_d[tail_q] = !(bus.resolve_valid && (bus.resolve_tag == bus.in_tag));
                tail_d         = tail_q + 1'b1;
            end
            if (deq) begin
                head_d = head_q + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // State register; reset discards every entry and marks all slots speculative.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            spec_q  <= '1;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            data_q  <= data_d;
            tag_q   <= tag_d;
            spec_q  <= spec_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = data_q[head_q];
    assign bus.count     = count_q;
endmodule

// File: tb/tb_spec_commit_buffer.sv
// Directed bench for spec_commit_buffer: a queue-based model predicts the
// outputs every cycle, and literal expectations pin key scenario points.
module tb_spec_commit_buffer;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int CNT_W = 3;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [TAG_W-1:0] tag;
        bit               spec;
    } entry_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    entry_t q[$];

    spec_commit_buffer_if #(.WIDTH(WIDTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) bus ();

    spec_commit_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Outputs the model says must be visible given its contents and current inputs.
    function automatic bit modelInReady();
        return (q.size() < DEPTH) && !bus.kill_valid;
    endfunction

    function automatic bit modelOutValid();
        if (q.size() == 0) return 1'b0;
        if (q[0].spec) return 1'b0;
        if (bus.kill_valid && (bus.kill_tag == q[0].tag)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic checkOutput();
        checkVal("in_ready", {31'd0, bus.in_ready}, {31'd0, modelInReady()});
        checkVal("out_valid", {31'd0, bus.out_valid}, {31'd0, modelOutValid()});
        checkVal("count", 32'(bus.count), 32'(q.size()));
        if (modelOutValid()) checkVal("out_data", 32'(bus.out_data), 32'(q[0].data));
    endtask

    // Advance the model across one rising edge using the inputs held this cycle.
    task automatic endCycle();
        bit deq;
        bit enq;
        int k;
        deq = modelOutValid() && bus.out_ready;
        enq = bus.in_valid && modelInReady();
        @(posedge clk);
        if (!rst) begin
            k = -1;
            if (bus.kill_valid) begin
                for (int i = q.size() - 1; i >= 0; i--)
                    if (q[i].tag == bus.kill_tag) k = i;
            end
            if (bus.resolve_valid) begin
                for (int i = 0; i < q.size(); i++)
                    if (q[i].tag == bus.resolve_tag) q[i].spec = 1'b0;
            end
            if (k >= 0) begin
                while (q.size() > k) void'(q.pop_back());
            end
            if (deq) void'(q.pop_front());
            if (enq) begin
                entry_t e;
                e.data = bus.in_data;
                e.tag  = bus.in_tag;
                e.spec = !(bus.resolve_valid && (bus.resolve_tag == bus.in_tag));
                q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic setInputs(input bit iv, input logic [WIDTH-1:0] din, input logic [TAG_W-1:0] itag,
                             input bit rv, input logic [TAG_W-1:0] rtag,
                             input bit kv, input logic [TAG_W-1:0] ktag, input bit ordy);
        bus.in_valid      = iv;
        bus.in_data       = din;
        bus.in_tag        = itag;
        bus.resolve_valid = rv;
        bus.resolve_tag   = rtag;
        bus.kill_valid    = kv;
        bus.kill_tag      = ktag;
        bus.out_ready     = ordy;
    endtask

    // Drive one cycle of inputs and compare against the model before the edge.
    task automatic applyStimulus(input bit iv, input logic [WIDTH-1:0] din, input logic [TAG_W-1:0] itag,
                                 input bit rv, input logic [TAG_W-1:0] rtag,
                                 input bit kv, input logic [TAG_W-1:0] ktag, input bit ordy);
        setInputs(iv, din, itag, rv, rtag, kv, ktag, ordy);
        #4;
        checkOutput();
    endtask

    task automatic step(input bit iv, input logic [WIDTH-1:0] din, input logic [TAG_W-1:0] itag,
                        input bit rv, input logic [TAG_W-1:0] rtag,
                        input bit kv, input logic [TAG_W-1:0] ktag, input bit ordy);
        applyStimulus(iv, din, itag, rv, rtag, kv, ktag, ordy);
        endCycle();
    endtask

    task automatic idleCheck();
        applyStimulus(0, 8'h00, 4'd0, 0, 4'd0, 0, 4'd0, 0);
    endtask

    task automatic drainCheck();
        applyStimulus(0, 8'h00, 4'd0, 0, 4'd0, 0, 4'd0, 1);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        setInputs(0, 8'h00, 4'd0, 0, 4'd0, 0, 4'd0, 0);
        #12;
        checkOutput();
        checkVal("reset count", 32'(bus.count), 32'd0);
        checkVal("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] basic flow");
        step(1, 8'hA1, 4'd1, 1, 4'd1, 0, 4'd0, 0);
        step(1, 8'hA2, 4'd2, 0, 4'd0, 0, 4'd0, 0);
        drainCheck();
        checkVal("basic out_valid", {31'd0, bus.out_valid}, 32'd1);
        checkVal("basic out_data", 32'(bus.out_data), 32'hA1);
        checkVal("basic count", 32'(bus.count), 32'd2);
        endCycle();
        idleCheck();
        checkVal("tag2 blocked", {31'd0, bus.out_valid}, 32'd0);
        endCycle();
        step(0, 8'h00, 4'd0, 1, 4'd2, 0, 4'd0, 0);
        drainCheck();
        checkVal("tag2 released", 32'(bus.out_data), 32'hA2);
        endCycle();

        $display("[TB] full and wrap");
        for (int i = 0; i < DEPTH; i++) step(1, 8'hB0 + 8'(i), 4'd3, 0, 4'd0, 0, 4'd0, 0);
        idleCheck();
        checkVal("full in_ready", {31'd0, bus.in_ready}, 32'd0);
        checkVal("full count", 32'(bus.count), 32'd4);
        endCycle();
        step(0, 8'h00, 4'd0, 1, 4'd3, 0, 4'd0, 0);
        applyStimulus(1, 8'hEE, 4'd7, 0, 4'd0, 0, 4'd0, 1);
        checkVal("no bypass in_ready", {31'd0, bus.in_ready}, 32'd0);
        checkVal("drain B0", 32'(bus.out_data), 32'hB0);
        endCycle();
        for (int i = 1; i < DEPTH; i++) begin
            drainCheck();
            checkVal("drain B", 32'(bus.out_data), 32'hB0 + 32'(i));
            endCycle();
        end
        for (int i = 0; i < DEPTH; i++) step(1, 8'hC0 + 8'(i), 4'd4, 1, 4'd4, 0, 4'd0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            drainCheck();
            checkVal("wrap C", 32'(bus.out_data), 32'hC0 + 32'(i));
            endCycle();
        end
        idleCheck();
        checkVal("wrap empty", 32'(bus.count), 32'd0);
        endCycle();

        $display("[TB] kill mid-queue");
        step(1, 8'hD1, 4'd1, 0, 4'd0, 0, 4'd0, 0);
        step(1, 8'hD2, 4'd2, 0, 4'd0, 0, 4'd0, 0);
        step(1, 8'hD3, 4'd2, 0, 4'd0, 0, 4'd0, 0);
        step(1, 8'hD4, 4'd3, 0, 4'd0, 0, 4'd0, 0);
        applyStimulus(0, 8'h00, 4'd0, 0, 4'd0, 1, 4'd2, 0);
        checkVal("kill in_ready", {31'd0, bus.in_ready}, 32'd0);
        endCycle();
        applyStimulus(1, 8'hD5, 4'd8, 1, 4'd8, 0, 4'd0, 0);
        checkVal("kill count", 32'(bus.count), 32'd1);
        endCycle();
        step(0, 8'h00, 4'd0, 1, 4'd1, 0, 4'd0, 0);
        drainCheck();
        checkVal("survivor D1", 32'(bus.out_data), 32'hD1);
        endCycle();
        drainCheck();
        checkVal("refill D5", 32'(bus.out_data), 32'hD5);
        endCycle();

        $display("[TB] kill at head");
        step(1, 8'hE5, 4'd5, 1, 4'd5, 0, 4'd0, 0);
        applyStimulus(0, 8'h00, 4'd0, 0, 4'd0, 1, 4'd5, 1);
        checkVal("head kill out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkVal("head kill in_ready", {31'd0, bus.in_ready}, 32'd0);
        endCycle();
        idleCheck();
        checkVal("head kill count", 32'(bus.count), 32'd0);
        endCycle();

        $display("[TB] kill with resolve and dequeue");
        step(1, 8'hF6, 4'd6, 1, 4'd6, 0, 4'd0, 0);
        step(1, 8'hF7, 4'd7, 0, 4'd0, 0, 4'd0, 0);
        step(1, 8'hF4, 4'd4, 0, 4'd0, 0, 4'd0, 0);
        step(1, 8'hF5, 4'd4, 0, 4'd0, 0, 4'd0, 0);
        applyStimulus(0, 8'h00, 4'd0, 1, 4'd4, 1, 4'd4, 1);
        checkVal("kill+deq data", 32'(bus.out_data), 32'hF6);
        endCycle();
        applyStimulus(0, 8'h00, 4'd0, 1, 4'd7, 0, 4'd0, 0);
        checkVal("kill+deq count", 32'(bus.count), 32'd1);
        endCycle();
        drainCheck();
        checkVal("survivor F7", 32'(bus.out_data), 32'hF7);
        endCycle();

        $display("[TB] async reset");
        step(1, 8'h91, 4'd1, 1, 4'd1, 0, 4'd0, 0);
        step(1, 8'h92, 4'd1, 0, 4'd0, 0, 4'd0, 0);
        step(1, 8'h93, 4'd1, 0, 4'd0, 0, 4'd0, 0);
        idleCheck();
        checkVal("pre-reset count", 32'(bus.count), 32'd3);
        #1;
        rst = 1'b1;
        q.delete();
        #1;
        checkOutput();
        checkVal("async count", 32'(bus.count), 32'd0);
        checkVal("async out_valid", {31'd0, bus.out_valid}, 32'd0);
        endCycle();
        rst = 1'b0;
        step(1, 8'h5A, 4'd2, 0, 4'd0, 0, 4'd0, 0);
        idleCheck();
        checkVal("post-reset tail", 32'(dut.tail_q), 32'd1);
        checkVal("post-reset slot0", 32'(dut.data_q[0]), 32'h5A);
        endCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
